// File: rtl/ram_march_bist.sv
// March C- built-in self-test engine for a small synchronous RAM.
// Drives the RAM ports directly and records the first failing location.
module ram_march_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CHECK,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [DATA_W-1:0] ONES     = '1;
    localparam logic [DATA_W-1:0] ZEROS    = '0;

    state_t            state;
    state_t            next_state;
    logic [2:0]        elem;
    logic [ADDR_W-1:0] addr;
    logic              descending;
    logic              last_addr;
    logic              accept;
    logic [DATA_W-1:0] rd_bg;
    logic [DATA_W-1:0] wr_bg;

    // E3/E4 walk downwards; E2/E4 read ones; E1/E3 write ones.
    assign descending = (elem == 3'd3) || (elem == 3'd4);
    assign rd_bg      = ((elem == 3'd2) || (elem == 3'd4)) ? ONES : ZEROS;
    assign wr_bg      = ((elem == 3'd1) || (elem == 3'd3)) ? ONES : ZEROS;
    assign last_addr  = descending ? (addr == '0) : (addr == ADDR_MAX);
    assign accept     = ((state == IDLE) || (state == DONE)) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = WRITE;
            WRITE:      if (addr == ADDR_MAX) next_state = READ;
            READ:       next_state = CHECK;
            CHECK:      next_state = (last_addr && (elem == 3'd5)) ? DONE : READ;
            default:    next_state = IDLE;
        endcase
    end

    // Address counter is reloaded at each element start and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            elem <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr <= '0;
                        elem <= 3'd0;
                    end
                end
                WRITE: begin
                    if (addr == ADDR_MAX) begin
                        addr <= '0;
                        elem <= 3'd1;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                CHECK: begin
                    if (last_addr) begin
                        if (elem != 3'd5) begin
                            elem <= elem + 3'd1;
                            addr <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
                        end
                    end else if (descending) begin
                        addr <= addr - ADDR_W'(1);
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Only the first mismatch of a run is captured; a new run clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (accept) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if ((state == CHECK) && (ram_dout != rd_bg) && !fail) begin
            fail      <= 1'b1;
            fail_addr <= addr;
            fail_exp  <= rd_bg;
            fail_got  <= ram_dout;
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            WRITE: begin
                busy     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = addr;
            end
            READ: begin
                busy     = 1'b1;
                ram_re   = 1'b1;
                ram_addr = addr;
            end
            CHECK: begin
                busy     = 1'b1;
                ram_addr = addr;
                if (elem != 3'd5) begin
                    ram_we  = 1'b1;
                    ram_din = wr_bg;
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Testbench for ram_march_bist: a faulty-RAM model plus an algorithmic
// March C- reference that predicts every RAM cycle and the first failure.
module tb_ram_march_bist;

    localparam int AW         = 4;
    localparam int DW         = 8;
    localparam int DEPTH      = 16;
    localparam int RUN_CYCLES = 176;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_got;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // RAM model with an optional stuck-at bit and an optional decoder alias.
    logic [DW-1:0] mem [DEPTH];
    logic          stuck_en = 1'b0;
    logic [AW-1:0] stuck_addr = '0;
    int            stuck_bit = 0;
    logic          stuck_val = 1'b0;
    logic          dec_en = 1'b0;
    logic [AW-1:0] dec_src = '0;
    logic [AW-1:0] dec_dst = '0;

    function automatic logic [DW-1:0] faulty_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (stuck_en && (a == stuck_addr)) r[stuck_bit] = stuck_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            if (dec_en && (ram_addr == dec_src)) mem[dec_dst] <= ram_din;
        end
        if (ram_re) ram_dout <= faulty_read(ram_addr, mem[ram_addr]);
    end

    // Reference: one entry per busy cycle, plus the predicted first failure.
    typedef struct {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    op_t           exp_ops[$];
    logic          exp_fail;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_exp, exp_got;

    task automatic build_model();
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] rbg, wbg, got;
        logic [AW-1:0] a;
        exp_ops.delete();
        exp_fail = 1'b0;
        exp_addr = '0;
        exp_exp  = '0;
        exp_got  = '0;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            a = AW'(i);
            exp_ops.push_back('{1'b1, 1'b0, a, 8'h00});
            m[a] = 8'h00;
            if (dec_en && (a == dec_src)) m[dec_dst] = 8'h00;
        end
        for (int e = 1; e <= 5; e++) begin
            rbg = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            wbg = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                a = (e == 3 || e == 4) ? AW'(DEPTH - 1 - i) : AW'(i);
                exp_ops.push_back('{1'b0, 1'b1, a, 8'h00});
                got = faulty_read(a, m[a]);
                if (got != rbg && !exp_fail) begin
                    exp_fail = 1'b1;
                    exp_addr = a;
                    exp_exp  = rbg;
                    exp_got  = got;
                end
                if (e < 5) begin
                    exp_ops.push_back('{1'b1, 1'b0, a, wbg});
                    m[a] = wbg;
                    if (dec_en && (a == dec_src)) m[dec_dst] = wbg;
                end else begin
                    exp_ops.push_back('{1'b0, 1'b0, a, 8'h00});
                end
            end
        end
    endtask

    // Protocol watch: no simultaneous we/re, and a write-back follows a read at the same address.
    logic          prev_re = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if ((ram_we && ram_re) || (ram_we && prev_re && (ram_addr !== prev_addr))) begin
                miscompares++;
                $display("[TB] FAIL protocol t=%0t: we=%b re=%b addr=%h prev_re=%b prev_addr=%h, required no we&re and matching addr",
                         $time, ram_we, ram_re, ram_addr, prev_re, prev_addr);
            end
        end
        prev_re   = ram_re;
        prev_addr = ram_addr;
    end

    task automatic clear_faults();
        stuck_en = 1'b0;
        dec_en   = 1'b0;
    endtask

    // Drives one complete run and compares every busy cycle and the end state with the model.
    task automatic run_march(input string tag, input int poke, input int hold);
        op_t e;
        logic ok;
        build_model();
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < RUN_CYCLES; c++) begin
            @(negedge clk);
            e = exp_ops[c];
            ok = (busy === 1'b1) && (done === 1'b0) && (ram_we === e.we) && (ram_re === e.re) &&
                 (ram_addr === e.addr) && (!e.we || (ram_din === e.din));
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("[TB] FAIL %s cycle %0d: got busy=%b done=%b we=%b re=%b addr=%h din=%h, required busy=1 done=0 we=%b re=%b addr=%h din=%h",
                         tag, c, busy, done, ram_we, ram_re, ram_addr, ram_din, e.we, e.re, e.addr, e.din);
            end
            if (c == 0) begin
                vectors++;
                if ({fail, fail_addr, fail_exp, fail_got} !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL %s clear_on_start: got fail=%b addr=%h exp=%h got=%h, required all 0",
                             tag, fail, fail_addr, fail_exp, fail_got);
                end
            end
            start = (c < hold) || (c == poke);
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b1 || ram_we !== 1'b0 || ram_re !== 1'b0 ||
            fail !== exp_fail || fail_addr !== exp_addr || fail_exp !== exp_exp || fail_got !== exp_got) begin
            miscompares++;
            $display("[TB] FAIL %s end: got busy=%b done=%b we=%b re=%b fail=%b addr=%h exp=%h got=%h, required busy=0 done=1 we=0 re=0 fail=%b addr=%h exp=%h got=%h",
                     tag, busy, done, ram_we, ram_re, fail, fail_addr, fail_exp, fail_got,
                     exp_fail, exp_addr, exp_exp, exp_got);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({busy, done, fail, fail_addr, fail_exp, fail_got, ram_we, ram_re, ram_addr, ram_din} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b fail=%b we=%b re=%b addr=%h din=%h, required all 0",
                     busy, done, fail, ram_we, ram_re, ram_addr, ram_din);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_healthy();
        clear_faults();
        run_march("healthy", -1, 0);
        vectors++;
        if (fail !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL healthy_pass: got fail=%b, required 0", fail);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_holds: got done=%b busy=%b, required 1 0", done, busy);
        end
    endtask

    task automatic test_stuck_bit();
        clear_faults();
        stuck_en = 1'b1; stuck_addr = 4'd5; stuck_bit = 3; stuck_val = 1'b1;
        run_march("stuck_a5_b3", -1, 0);
        vectors++;
        if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_exp !== 8'h00 || fail_got !== 8'h08) begin
            miscompares++;
            $display("[TB] FAIL stuck_capture: got fail=%b addr=%h exp=%h got=%h, required 1 5 00 08",
                     fail, fail_addr, fail_exp, fail_got);
        end
    endtask

    task automatic test_decoder();
        clear_faults();
        dec_en = 1'b1; dec_src = 4'd9; dec_dst = 4'd6;
        run_march("decoder_9_to_6", -1, 0);
        vectors++;
        if (fail !== 1'b1 || fail_addr !== 4'd6 || fail_exp !== 8'h00 || fail_got !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL decoder_capture: got fail=%b addr=%h exp=%h got=%h, required 1 6 00 FF",
                     fail, fail_addr, fail_exp, fail_got);
        end
    endtask

    task automatic test_rerun_after_fail();
        clear_faults();
        run_march("rerun_healthy", -1, 0);
        vectors++;
        if (fail !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rerun_pass: got fail=%b done=%b, required 0 1", fail, done);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_faults();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, fail, fail_addr, fail_exp, fail_got, ram_we, ram_re, ram_addr, ram_din} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_run: got busy=%b done=%b fail=%b we=%b re=%b addr=%h din=%h, required all 0",
                     busy, done, fail, ram_we, ram_re, ram_addr, ram_din);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_mid_reset: got busy=%b done=%b, required 0 0", busy, done);
        end
        run_march("after_mid_reset", -1, 0);
    endtask

    task automatic test_start_while_busy();
        clear_faults();
        run_march("start_at_30", 30, 0);
    endtask

    task automatic test_back_to_back();
        clear_faults();
        run_march("b2b_first", -1, 0);
        run_march("b2b_held", -1, 4);
    endtask

    task automatic test_random_faults();
        int kind;
        for (int n = 0; n < 6; n++) begin
            clear_faults();
            kind = int'($urandom_range(0, 2));
            if (kind == 1) begin
                stuck_en   = 1'b1;
                stuck_addr = AW'($urandom_range(0, DEPTH - 1));
                stuck_bit  = int'($urandom_range(0, DW - 1));
                stuck_val  = 1'($urandom_range(0, 1));
            end else if (kind == 2) begin
                dec_en  = 1'b1;
                dec_src = AW'($urandom_range(0, DEPTH - 1));
                dec_dst = AW'($urandom_range(0, DEPTH - 2));
                if (dec_dst >= dec_src) dec_dst = dec_dst + AW'(1);
            end
            run_march($sformatf("random_%0d_kind%0d", n, kind), -1, 0);
        end
        clear_faults();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        test_reset();
        test_healthy();
        test_stuck_bit();
        test_rerun_after_fail();
        test_decoder();
        test_reset_mid_run();
        test_start_while_busy();
        test_back_to_back();
        test_random_faults();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
